instr_controller: RTL and testbench

INSTR_CONTROLLER -- requirements
Module: instr_controller

---
 rtl/proc_pkg.sv | 36 +++
 rtl/instr_controller_if.sv | 29 ++
 rtl/alu16.sv | 25 ++
 rtl/instr_controller.sv | 117 +++++++++++
 tb/tb_instr_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the small instruction controller:
// opcodes, FSM states and instruction field positions.
package proc_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultPcWidth   = 8;
  localparam int unsigned InstrWidth       = 16;

  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdLsb     = 10;
  localparam int unsigned Rs1Lsb    = 8;
  localparam int unsigned Rs2Lsb    = 6;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned OffLsb    = 0;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpLi   = 4'h6,
    OpBeq  = 4'h7,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/instr_controller_if.sv
// Instruction-memory fetch handshake plus register-file read/write port.
interface instr_controller_if
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned PC_WIDTH   = DefaultPcWidth
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_valid;
  logic [InstrWidth-1:0] imem_data;
  logic [1:0]            rs1;
  logic [1:0]            rs2;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [1:0]            rd;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output imem_req, imem_addr, rs1, rs2, rd, wr_en, wr_data,
    input  imem_valid, imem_data, op1, op2
  );

  modport slave (
    input  imem_req, imem_addr, rs1, rs2, rd, wr_en, wr_data,
    output imem_valid, imem_data, op1, op2
  );
endinterface

// File: rtl/alu16.sv
// Combinational ALU for the register-register opcodes; results wrap modulo 2^DATA_WIDTH.
module alu16
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OpAdd:   result = a + b;
      OpSub:   result = a - b;
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_controller.sv
// Multi-cycle FETCH/DECODE/EXEC controller driving an external register file and
// instruction memory; write data and strobes are registered out of DECODE.
module instr_controller
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned PC_WIDTH   = DefaultPcWidth
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_controller_if.master  bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [InstrWidth-1:0] ir_q;
  logic                  wr_en_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [3:0]            opc;
  logic                  writes;
  logic                  legal;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0]   off_ext;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   pc_br;

  assign opc     = ir_q[OpcodeLsb +: 4];
  assign imm_ext = DATA_WIDTH'(ir_q[ImmLsb +: 8]);
  assign off_ext = {{(PC_WIDTH-6){ir_q[OffLsb+5]}}, ir_q[OffLsb +: 6]};
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign pc_br   = pc_inc + off_ext;

  alu16 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (opc),
    .a     (bus.op1),
    .b     (bus.op2),
    .result(alu_res)
  );

  always_comb begin
    writes = 1'b0;
    legal  = 1'b1;
    case (opc)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpLi: writes = 1'b1;
      OpNop, OpBeq, OpHalt:                   writes = 1'b0;
      default:                                legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= '0;
          end
        end
        StFetch: begin
          if (bus.imem_valid) begin
            ir_q    <= bus.imem_data;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          // Operands are read here so the EXEC-cycle outputs come straight from flops.
          wr_en_q   <= writes;
          wr_data_q <= (opc == OpLi) ? imm_ext : alu_res;
          illegal_q <= ~legal;
          state_q   <= StExec;
        end
        StExec: begin
          wr_en_q   <= 1'b0;
          illegal_q <= 1'b0;
          if (opc == OpHalt) begin
            state_q <= StHalt;
          end else begin
            pc_q    <= (opc == OpBeq && bus.op1 == bus.op2) ? pc_br : pc_inc;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req  = (state_q == StFetch);
  assign bus.imem_addr = pc_q;
  assign bus.rs1       = ir_q[Rs1Lsb +: 2];
  assign bus.rs2       = ir_q[Rs2Lsb +: 2];
  assign bus.rd        = ir_q[RdLsb +: 2];
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;

  assign pc      = pc_q;
  assign busy    = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller with a behavioural register file and instruction ROM.
module tb_instr_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       illegal;

  instr_controller_if #(.DATA_WIDTH(16), .PC_WIDTH(8)) bus ();

  instr_controller #(
    .DATA_WIDTH(16),
    .PC_WIDTH  (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [15:0] rf  [4];
  int          dly = 0;
  int          wait_cnt = 0;

  assign bus.imem_data  = rom[bus.imem_addr];
  assign bus.imem_valid = bus.imem_req && (wait_cnt >= dly);
  assign bus.op1        = rf[bus.rs1];
  assign bus.op2        = rf[bus.rs2];

  always_ff @(posedge clk) wait_cnt <= (bus.imem_req && !bus.imem_valid) ? wait_cnt + 1 : 0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf[0] <= 16'h0000;
      rf[1] <= 16'h0000;
      rf[2] <= 16'h0001;
      rf[3] <= 16'h0000;
    end else if (bus.wr_en) begin
      rf[bus.rd] <= bus.wr_data;
    end
  end

  typedef struct packed {
    logic [3:0][15:0] prog;
    int               n;
    int               delay;
    logic [3:0][15:0] er;
    logic [7:0]       epc;
    int               ewr;
    int               eill;
    int               ecyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, input int n, input int dl,
                              input logic [15:0] r0, r1, r2, r3, input logic [7:0] epc,
                              input int ewr, input int eill, input int ecyc);
    vec_t v;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
    v.n = n; v.delay = dl;
    v.er[0] = r0; v.er[1] = r1; v.er[2] = r2; v.er[3] = r3;
    v.epc = epc; v.ewr = ewr; v.eill = eill; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < v.n; i++) rom[i] = v.prog[i];
    dly = v.delay;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start, then step on negedges until halted (bounded), tallying write and illegal cycles.
  task automatic run_prog(output int cyc, output int nwr, output int nill);
    logic       pw;
    logic [7:0] pa;
    pw = 1'b0;
    pa = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nwr = 0; nill = 0;
    while (!halted && cyc < 300) begin
      if (bus.wr_en) nwr++;
      if (illegal) nill++;
      if (pw) chk("imem_hold", {23'd0, bus.imem_req, bus.imem_addr}, {23'd0, 1'b1, pa});
      pw = bus.imem_req && !bus.imem_valid;
      pa = bus.imem_addr;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, nwr, nill, k;

    vecs[0] = mk(16'h1680, 16'hF000, 16'h0, 16'h0, 2, 0,
                 16'h0000, 16'h0002, 16'h0001, 16'h0000, 8'd1, 1, 0, 6);
    vecs[1] = mk(16'h2080, 16'h0, 16'h0, 16'h0, 1, 0,
                 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 8'd1, 1, 0, 6);
    vecs[2] = mk(16'h6CA5, 16'h7001, 16'h6C00, 16'hF000, 4, 0,
                 16'h0000, 16'h0000, 16'h0001, 16'h00A5, 8'd3, 1, 0, 9);
    vecs[3] = mk(16'h1680, 16'hF000, 16'h0, 16'h0, 2, 3,
                 16'h0000, 16'h0002, 16'h0001, 16'h0000, 8'd1, 1, 0, 12);
    vecs[4] = mk(16'h8000, 16'hF000, 16'h0, 16'h0, 2, 0,
                 16'h0000, 16'h0000, 16'h0001, 16'h0000, 8'd1, 0, 1, 6);
    vecs[5] = mk(16'h643C, 16'h5E40, 16'h3280, 16'hF000, 4, 0,
                 16'h0001, 16'h003C, 16'h0001, 16'h003D, 8'd3, 3, 0, 12);

    // Reset values.
    load(vecs[0]);
    #12;
    chk("rst_ctrl", {27'd0, bus.imem_req, bus.wr_en, illegal, busy, halted}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_sel", {26'd0, bus.rs1, bus.rs2, bus.rd}, 32'd0);
    chk("rst_wdata", bus.wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_stays", {30'd0, busy, bus.imem_req}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      load(vecs[i]);
      do_reset();
      run_prog(cyc, nwr, nill);
      for (int r = 0; r < 4; r++) chk($sformatf("v%0d_r%0d", i, r), rf[r], vecs[i].er[r]);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("v%0d_state", i), {30'd0, halted, busy}, 32'd2);
      chk($sformatf("v%0d_wr", i), nwr, vecs[i].ewr);
      chk($sformatf("v%0d_ill", i), nill, vecs[i].eill);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].ecyc);
    end

    // Reset asserted during the EXEC cycle of ADD.
    load(vecs[0]);
    do_reset();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!bus.wr_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("exec_reached", bus.wr_en, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", bus.wr_en, 32'd0);
    chk("abort_state", {29'd0, busy, halted, bus.imem_req}, 32'd0);
    chk("abort_pc", pc, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_r1", rf[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", {30'd0, busy, halted}, 32'd0);
    chk("abort_idle_pc", pc, 32'd0);

    // start while busy is ignored; start in HALT restarts from pc 0.
    load(vecs[5]);
    do_reset();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 300) begin
      start = (cyc == 4);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("busy_start_cycles", cyc, 32'd12);
    chk("busy_start_pc", pc, 32'd3);
    chk("busy_start_r3", rf[3], 32'h3D);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {30'd0, busy, halted}, 32'd2);
    chk("restart_pc", {bus.imem_addr, pc}, 32'd0);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("restart_cycles", cyc, 32'd12);
    chk("restart_pc_end", pc, 32'd3);
    chk("restart_r0", rf[0], 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
